// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int OS_RATE_DEF = 16;

    // Odd-ones indicator; callers zero-extend narrower payloads.
    function automatic logic odd_ones(input logic [31:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage bit synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ff <= '1;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start validation, 3-sample majority voting, parity/stop checks,
// and a valid/ready holding register with overrun reporting.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low on a tick
// START  | start bit: mid-bit validation, then run to end of bit
// DATA   | receiving DATA_BITS payload bits, LSB first
// PARITY | receiving the parity bit
// STOP   | stop bit; frame completes on its mid-bit vote
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OS_RATE     = OS_RATE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 en,
    input  logic                 os_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OS_RATE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] T_S1   = TICK_W'(OS_RATE/2 - 2);
    localparam logic [TICK_W-1:0] T_S2   = TICK_W'(OS_RATE/2 - 1);
    localparam logic [TICK_W-1:0] T_MID  = TICK_W'(OS_RATE/2);
    localparam logic [TICK_W-1:0] T_LAST = TICK_W'(OS_RATE - 1);
    localparam logic [BIT_W-1:0]  B_LAST = BIT_W'(DATA_BITS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic                   rx_s;
    logic [TICK_W-1:0]      tick_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [1:0]             samp;
    logic                   vote;
    logic                   bit_val;
    logic                   par_bit;
    logic                   par_used;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   frame_done;
    logic                   load;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .arst (arst),
        .d    (rx),
        .q    (rx_s)
    );

    // Third sample is the live rx_s at T_MID; the first two were captured on earlier ticks.
    assign vote = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // START runs on to the end of the start bit so DATA tick counts are bit-relative
    // and the three samples straddle each bit centre.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else if (os_tick) begin
            case (state)
                IDLE:   if (!rx_s) state_nxt = START;
                START: begin
                    if (tick_cnt == T_S2 && rx_s) state_nxt = IDLE;
                    else if (tick_cnt == T_LAST)  state_nxt = DATA;
                end
                DATA: begin
                    if (tick_cnt == T_LAST && bit_cnt == B_LAST)
                        state_nxt = parity_en ? PARITY : STOP;
                end
                PARITY: if (tick_cnt == T_LAST) state_nxt = STOP;
                STOP:   if (tick_cnt == T_MID) state_nxt = vote ? IDLE : BREAK;
                BREAK:  if (rx_s) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        frame_done = en && os_tick && (state == STOP) && (tick_cnt == T_MID);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            samp      <= '0;
            bit_val   <= 1'b0;
            par_bit   <= 1'b0;
            par_used  <= 1'b0;
            shift_reg <= '0;
        end else if (!en) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (os_tick) begin
            if (tick_cnt == T_S1) samp[1] <= rx_s;
            if (tick_cnt == T_S2) samp[0] <= rx_s;
            case (state)
                IDLE, BREAK: tick_cnt <= '0;
                default:     tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            endcase
            if (state == START) bit_cnt <= '0;
            if (state == DATA) begin
                if (tick_cnt == T_MID) bit_val <= vote;
                if (tick_cnt == T_LAST) begin
                    shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == B_LAST) par_used <= parity_en;
                end
            end
            if (state == PARITY && tick_cnt == T_MID) par_bit <= vote;
        end
    end

    // A completing frame may land in the same clk the consumer drains the register.
    assign load = frame_done && (!data_valid || data_ready);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= frame_done && !load;
            if (load) begin
                data_out   <= shift_reg;
                frame_err  <= !vote;
                parity_err <= par_used && (odd_ones(32'(shift_reg)) ^ par_bit ^ parity_odd);
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver: the receiving end for the team's UART transmitter when the transmitter drives an external or asynchronous line.
- Synchronises the raw serial input, validates start bits, majority-votes each bit, and checks parity and stop bit.
- Presents each received byte on a valid/ready holding register with error flags.
- Sits beside baud_gen, which is programmed for OS_RATE× the baud rate and supplies os_tick.

Parameters:
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- OS_RATE, 16, os_tick pulses per bit period; must be even and ≥ 8.
- SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser.

Ports:
- clk  in  1  single system clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low forces the FSM to IDLE.
- os_tick  in  1  one-clk pulse at OS_RATE× the baud rate.
- rx  in  1  asynchronous serial line; idles high.
- parity_en  in  1  1 = a parity bit follows the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even; ignored when parity_en=0.
- data_out  out  DATA_BITS  received byte (holding register).
- data_valid  out  1  holding register full.
- data_ready  in  1  consumer accepts data when high together with data_valid.
- frame_err  out  1  stop bit sampled low; registered with data_out.
- parity_err  out  1  parity mismatch; registered with data_out.
- overrun  out  1  one-clk pulse when a completed frame is dropped.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async):
  - All synchroniser flops set to 1; FSM = IDLE; counters = 0.
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
- Synchroniser: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- FSM state changes and counter updates happen only on clk edges where os_tick=1. The exception is en=0, which forces IDLE on any clk edge and clears the counters. The holding register is untouched by en.
- IDLE:
  - On os_tick with rx_s=0, go to START and clear the tick counter.
- START:
  - On tick count OS_RATE/2-1 (mid start bit), sample rx_s.
  - rx_s=1: false start, return to IDLE, no flags raised.
  - rx_s=0: go to DATA and reset the tick and bit counters.
- DATA:
  - The tick counter wraps at OS_RATE-1.
  - Samples are taken at tick counts OS_RATE/2-2, OS_RATE/2-1 and OS_RATE/2; the bit value is the majority of the three.
  - At tick OS_RATE-1, shift the bit into the shift register from the MSB side (LSB-first line order).
  - After DATA_BITS bits: go to PARITY if parity_en=1, else STOP.
- PARITY:
  - Majority-vote one bit.
  - Parity error if XOR(data bits, parity bit) differs from parity_odd.
- STOP:
  - Sample at mid-bit using majority vote; stop=0 means framing error.
  - Frame completion occurs on the mid-bit os_tick. The FSM does not wait for the end of the stop bit.
  - stop=1: go to IDLE.
  - stop=0 (break or glitch): go to BREAK.
- BREAK: wait until rx_s=1 on an os_tick, then go to IDLE. This prevents a false restart on a held-low line.
- Frame completion, in the same clk as the stop sample:
  - If data_valid=0, or data_valid=1 with data_ready=1 in that same clk: load data_out, frame_err and parity_err; data_valid=1.
  - Otherwise: drop the frame, keep the old contents, and pulse overrun for 1 clk.
- Handshake:
  - data_valid falls on the clk after data_valid&data_ready, unless a simultaneous load occurs, in which case it stays 1 with the new data.
  - data_out, frame_err and parity_err are stable while data_valid=1.
- Latency: data_valid rises one clk after the os_tick edge that samples the stop bit.
- Reset mid-frame: immediate return to IDLE; any partially received data is discarded.

Decomposition:
- Shared package uart_pkg holds:
  - state typedef (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the OS_RATE default constant;
  - the parity helper function.
- One natural sub-module: uart_sync, the SYNC_STAGES bit synchroniser with reset value 1. The FSM, voting and holding register stay in uart_rx_os.

Test Plan:
- Common setup: OS_RATE=16; os_tick every 4 clk (one bit = 64 clk); parity_en=0; data_ready=1.
- Basic frame: send 0x55 → data_out=0x55, data_valid for 1 clk, frame_err=0, parity_err=0, busy low after the stop sample.
- Parity: parity_en=1, parity_odd=0, send 0xA3 with parity bit 0 → parity_err=0. Repeat with parity bit 1 → parity_err=1, data_out=0xA3.
- False start and glitch rejection:
  - Drive rx low for 4 os_ticks, then high → no data_valid, FSM back in IDLE.
  - Single-tick glitch at bit-3 centre of 0x00 → data_out=0x00 (majority vote).
- Framing error and break: send 0x3C with the stop bit low, then hold rx low for 3 bit times → frame_err=1, data_out=0x3C, busy held until rx returns high. Next frame 0x81 → frame_err=0.
- Overrun and backpressure: data_ready=0, send 0x11 then 0x22 → data_out stays 0x11, one overrun pulse. Raise data_ready → data_valid falls next clk.
- Async reset mid-frame: assert arst during bit 4 of 0xF0 → all outputs 0 immediately. Next frame 0x0F is received correctly.
